// File: rtl/pew_scheduler.sv
// pew_scheduler: round-robin owner of the shared trigger/pew emitter.
// A granted burst is one trigger pre-pulse, then N pew pulses separated by
// gaps, then an optional cooldown. All outputs are registered.
module pew_scheduler #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned TW       = 24,
    parameter int unsigned TRIG_CYC = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            abort,
    input  logic [TW-1:0]   cfg_pulse,
    input  logic [TW-1:0]   cfg_gap,
    input  logic [TW-1:0]   cfg_cool,
    input  logic [3:0]      cfg_count,
    output logic [NREQ-1:0] grant,
    output logic            done,
    output logic            busy,
    output logic            trigger,
    output logic            pew,
    output logic [3:0]      status
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StFire = 2'd2,
        StWait = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [3:0]      shots_q, shots_d;
    logic            cool_q, cool_d;      // WAIT is the cooldown, not a gap
    logic [TW-1:0]   pulse_q, pulse_d;
    logic [TW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   cooltime_q, cooltime_d;
    logic [1:0]      last_q, last_d;      // last granted requester
    logic [1:0]      idx_q, idx_d;        // current owner
    logic [NREQ-1:0] grant_d;
    logic            done_d;
    logic            end_burst;

    logic [1:0]      win;
    logic            found;
    int unsigned     cand;
    logic [NREQ-1:0] req_sh;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win    = 2'b00;
        found  = 1'b0;
        cand   = 0;
        req_sh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand   = ({30'd0, last_q} + 32'd1 + i) % NREQ;
            req_sh = req >> cand;
            if (!found && req_sh[0]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    // Next-state logic: burst sequencing, config latch, abort handling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shots_d    = shots_q;
        cool_d     = cool_q;
        pulse_d    = pulse_q;
        gap_d      = gap_q;
        cooltime_d = cooltime_q;
        last_d     = last_q;
        idx_d      = idx_q;
        grant_d    = grant;
        done_d     = 1'b0;
        end_burst  = 1'b0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StArm;
                    cnt_d      = TW'(TRIG_CYC);
                    idx_d      = win;
                    grant_d    = NREQ'(1) << win;
                    // Zero-valued fields are promoted here so the datapath never sees them.
                    pulse_d    = (cfg_pulse == '0) ? TW'(1) : cfg_pulse;
                    gap_d      = (cfg_gap == '0) ? TW'(1) : cfg_gap;
                    cooltime_d = cfg_cool;
                    shots_d    = (cfg_count == 4'd0) ? 4'd1 : cfg_count;
                    cool_d     = 1'b0;
                end
            end
            StArm: begin
                if (cnt_q == TW'(1)) begin
                    state_d = StFire;
                    cnt_d   = pulse_q;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StFire: begin
                if (cnt_q == TW'(1)) begin
                    shots_d = shots_q - 4'd1;
                    if (shots_q > 4'd1) begin
                        state_d = StWait;
                        cool_d  = 1'b0;
                        cnt_d   = gap_q;
                    end else if (cooltime_q != '0) begin
                        state_d = StWait;
                        cool_d  = 1'b1;
                        cnt_d   = cooltime_q;
                    end else begin
                        end_burst = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StWait: begin
                if (cnt_q == TW'(1)) begin
                    if (cool_q) begin
                        end_burst = 1'b1;
                    end else begin
                        state_d = StFire;
                        cnt_d   = pulse_q;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && abort) begin
            end_burst = 1'b1;
        end

        // Normal end and abort both release the emitter and rotate priority.
        if (end_burst) begin
            state_d = StIdle;
            done_d  = 1'b1;
            grant_d = '0;
            last_d  = idx_q;
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shots_q    <= 4'd0;
            cool_q     <= 1'b0;
            pulse_q    <= '0;
            gap_q      <= '0;
            cooltime_q <= '0;
            last_q     <= 2'(NREQ - 1);
            idx_q      <= 2'b00;
            grant      <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            trigger    <= 1'b0;
            pew        <= 1'b0;
            status     <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shots_q    <= shots_d;
            cool_q     <= cool_d;
            pulse_q    <= pulse_d;
            gap_q      <= gap_d;
            cooltime_q <= cooltime_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            grant      <= grant_d;
            done       <= done_d;
            busy       <= (state_d != StIdle);
            trigger    <= (state_d == StArm);
            pew        <= (state_d == StFire);
            status     <= {((state_d == StIdle) ? 2'b00 : idx_d), state_d};
        end
    end

endmodule

// File: tb/tb_pew_scheduler.sv
// Directed bench for pew_scheduler (NREQ=2, TW=24, TRIG_CYC=10).
module tb_pew_scheduler;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TW   = 24;
    localparam int unsigned TRIG = 10;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            abort;
    logic [TW-1:0]   cfg_pulse;
    logic [TW-1:0]   cfg_gap;
    logic [TW-1:0]   cfg_cool;
    logic [3:0]      cfg_count;
    logic [NREQ-1:0] grant;
    logic            done;
    logic            busy;
    logic            trigger;
    logic            pew;
    logic [3:0]      status;

    int vectors;
    int miscompares;

    pew_scheduler #(
        .NREQ     (NREQ),
        .TW       (TW),
        .TRIG_CYC (TRIG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .abort     (abort),
        .cfg_pulse (cfg_pulse),
        .cfg_gap   (cfg_gap),
        .cfg_cool  (cfg_cool),
        .cfg_count (cfg_count),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .trigger   (trigger),
        .pew       (pew),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bundle layout: {grant[1:0], done, busy, trigger, pew, status[3:0]}.
    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {grant, done, busy, trigger, pew, status};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed grant=%b done=%b busy=%b trig=%b pew=%b status=%h, expected grant=%b done=%b busy=%b trig=%b pew=%b status=%h",
                   tag, obs[9:8], obs[7], obs[6], obs[5], obs[4], obs[3:0],
                   exp[9:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    localparam logic [9:0] IDLE_DONE = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    localparam logic [9:0] IDLE_QUIET = 10'd0;

    // Expected outputs in cycle k (k=1 is the first cycle after the grant edge)
    // for a burst by requester win with effective pulse p, gap g, count n, cooldown c.
    function automatic logic [9:0] exp_burst(input int k, input int win, input int p,
                                             input int g, input int n, input int c);
        int         len;
        int         o;
        logic       tr;
        logic       pw;
        logic [1:0] st;
        logic [1:0] gr;
        len = TRIG + n * p + (n - 1) * g + c;
        if (k == len + 1) return IDLE_DONE;
        tr = (k <= TRIG);
        o  = k - TRIG - 1;
        pw = (k > TRIG) && (o < n * p + (n - 1) * g) && ((o % (p + g)) < p);
        st = tr ? 2'd1 : (pw ? 2'd2 : 2'd3);
        gr = (win == 0) ? 2'b01 : 2'b10;
        return {gr, 1'b0, 1'b1, tr, pw, 2'(win), st};
    endfunction

    // Runs a full burst from the arbitration edge through the done cycle.
    task automatic run_burst(input string tag, input int win, input int p, input int g,
                             input int n, input int c, input bit scramble);
        int len;
        len = TRIG + n * p + (n - 1) * g + c;
        for (int k = 1; k <= len + 1; k++) begin
            tick();
            if (k == 1 && scramble) begin
                cfg_pulse = 24'd7;
                cfg_gap   = 24'd9;
                cfg_count = 4'd2;
                cfg_cool  = 24'd5;
            end
            chk($sformatf("%s k=%0d", tag, k), exp_burst(k, win, p, g, n, c));
        end
    endtask

    task automatic set_cfg(input int p, input int g, input int n, input int c);
        cfg_pulse = TW'(p);
        cfg_gap   = TW'(g);
        cfg_count = 4'(n);
        cfg_cool  = TW'(c);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 2'b00;
        abort       = 1'b0;
        set_cfg(0, 0, 0, 0);

        // Reset values
        tick();
        tick();
        chk("reset", IDLE_QUIET);
        rst = 1'b0;
        tick();
        chk("idle after reset", IDLE_QUIET);

        // Single shot: 10 trigger cycles, 5 pew cycles, done at t+16
        req = 2'b01;
        set_cfg(5, 0, 1, 0);
        run_burst("single", 0, 5, 1, 1, 0, 1'b0);
        req = 2'b00;
        tick();
        chk("single quiet", IDLE_QUIET);

        // Burst 4H-2L-4H-2L-4H + 6 cooldown, req held, config scrambled mid-burst
        req = 2'b01;
        set_cfg(4, 2, 3, 6);
        run_burst("burst1", 0, 4, 2, 3, 6, 1'b1);
        set_cfg(4, 2, 3, 6);
        run_burst("burst2", 0, 4, 2, 3, 6, 1'b0);
        req = 2'b00;
        tick();
        chk("burst quiet", IDLE_QUIET);

        // Contention: alternating grants, only the done cycle in between
        req = 2'b11;
        set_cfg(2, 1, 2, 0);
        run_burst("cont1", 1, 2, 1, 2, 0, 1'b0);
        run_burst("cont2", 0, 2, 1, 2, 0, 1'b0);
        run_burst("cont3", 1, 2, 1, 2, 0, 1'b0);
        req = 2'b00;
        tick();
        chk("cont quiet", IDLE_QUIET);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        chk("abort idle", IDLE_QUIET);
        abort = 1'b0;

        // Zero config behaves as pulse=1, count=1, no cooldown
        req = 2'b01;
        set_cfg(0, 0, 0, 0);
        run_burst("zero", 0, 1, 1, 1, 0, 1'b0);
        req = 2'b00;

        // Abort during the 2nd FIRE of a 3-shot burst by requester 1
        set_cfg(3, 2, 3, 4);
        req = 2'b10;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) req = 2'b00;
            chk($sformatf("abort burst k=%0d", k), exp_burst(k, 1, 3, 2, 3, 4));
        end
        abort = 1'b1;
        tick();
        chk("abort done", IDLE_DONE);
        abort = 1'b0;
        req   = 2'b11;
        tick();
        chk("after abort favours req0", exp_burst(1, 0, 3, 2, 3, 4));

        // Abort in ARM, then reset during WAIT(gap) of a requester-1 burst
        abort = 1'b1;
        tick();
        chk("abort in arm", IDLE_DONE);
        abort = 1'b0;
        req   = 2'b10;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk($sformatf("pre-reset k=%0d", k), exp_burst(k, 1, 3, 2, 3, 4));
        end
        rst = 1'b1;
        tick();
        chk("reset mid gap", IDLE_QUIET);
        rst = 1'b0;
        req = 2'b11;
        tick();
        chk("pointer reset", exp_burst(1, 0, 3, 2, 3, 4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
